// File: rtl/fwd_scoreboard_pkg.sv
// Shared stage indices, result-availability encodings and producer-table entry type
// for the operand-forwarding scoreboard.
package fwd_scoreboard_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned AVAIL_W = 4;

  localparam int unsigned STG_D = 0;
  localparam int unsigned STG_E = 1;
  localparam int unsigned STG_M = 2;
  localparam int unsigned STG_W = 3;

  // First stage whose pipeline register holds the produced value
  localparam int unsigned AVAIL_JAL  = 1;
  localparam int unsigned AVAIL_ALU  = 2;
  localparam int unsigned AVAIL_LOAD = 3;

  typedef struct packed {
    logic               valid;
    logic [REG_W-1:0]   addr;
    logic [AVAIL_W-1:0] avail;
  } entry_t;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// D-stage producer info, read-port queries and forwarding/stall results.
interface fwd_scoreboard_if #(
  parameter int unsigned NUM_RD = 4,
  parameter int unsigned SW     = 2
);
  logic                 d_valid;
  logic                 d_wr_en;
  logic [4:0]           d_wr_addr;
  logic [SW-1:0]        d_avail;
  logic                 d_md_use;
  logic                 md_start;
  logic                 flush_e;
  logic [NUM_RD*5-1:0]  rd_addr;
  logic [NUM_RD*SW-1:0] rd_stage;
  logic [NUM_RD*SW-1:0] rd_need;
  logic [NUM_RD*SW-1:0] fwd_sel;
  logic [NUM_RD-1:0]    fwd_rdy;
  logic                 stall;

  modport master (
    output d_valid, d_wr_en, d_wr_addr, d_avail, d_md_use, md_start, flush_e,
           rd_addr, rd_stage, rd_need,
    input  fwd_sel, fwd_rdy, stall
  );

  modport slave (
    input  d_valid, d_wr_en, d_wr_addr, d_avail, d_md_use, md_start, flush_e,
           rd_addr, rd_stage, rd_need,
    output fwd_sel, fwd_rdy, stall
  );
endinterface

// File: rtl/fwd_port_match.sv
// One read port: finds the youngest producer older than the reader and derives
// forward select, readiness and the load-use hazard.
module fwd_port_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SW    = 2
) (
  input  entry_t [DEPTH:1]  tbl_i,
  input  logic [REG_W-1:0]  rd_addr_i,
  input  logic [SW-1:0]     rd_stage_i,
  input  logic [SW-1:0]     rd_need_i,
  output logic [SW-1:0]     sel_o,
  output logic              rdy_o,
  output logic              hazard_o
);

  logic found;

  // Ascending scan with a found flag keeps the lowest (youngest) matching stage
  always_comb begin
    sel_o    = '0;
    rdy_o    = 1'b1;
    hazard_o = 1'b0;
    found    = 1'b0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!found && tbl_i[k].valid && (rd_addr_i != '0) &&
          (tbl_i[k].addr == rd_addr_i) && (k > 32'(rd_stage_i))) begin
        found    = 1'b1;
        sel_o    = SW'(k);
        rdy_o    = 32'(tbl_i[k].avail) <= k;
        hazard_o = (32'(rd_stage_i) == STG_D) &&
                   (32'(tbl_i[k].avail) > k + 32'(rd_need_i));
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard: shifts a producer table down the pipe, resolves
// per-port forwarding and raises stall for load-use and mult/div-busy hazards.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_RD = 4,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned MD_LAT = 5,
  parameter int unsigned SW     = 2
) (
  input logic clk,
  input logic reset,
  fwd_scoreboard_if.slave bus
);

  localparam int unsigned CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  entry_t [DEPTH:1]     tbl_q, tbl_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_RD*SW-1:0] sel_w;
  logic [NUM_RD-1:0]    rdy_w;
  logic [NUM_RD-1:0]    haz_w;
  logic                 md_haz_c;
  logic                 stall_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_q <= '0;
      cnt_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      cnt_q <= cnt_d;
    end
  end

  // Table advances every cycle; a stalled or flushed D slot enters E as a bubble
  always_comb begin
    tbl_d = tbl_q;
    for (int unsigned k = DEPTH; k >= 2; k--) begin
      tbl_d[k] = tbl_q[k-1];
    end
    tbl_d[1] = '0;
    if (!(stall_c || bus.flush_e)) begin
      tbl_d[1].valid = bus.d_valid & bus.d_wr_en & (bus.d_wr_addr != '0);
      tbl_d[1].addr  = bus.d_wr_addr;
      tbl_d[1].avail = AVAIL_W'(bus.d_avail);
    end
  end

  // Counter holds busy cycles remaining after the current one; the start cycle is itself busy
  always_comb begin
    cnt_d = cnt_q;
    if (bus.md_start) begin
      cnt_d = CW'(MD_LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_port_match #(
      .DEPTH (DEPTH),
      .SW    (SW)
    ) u_match (
      .tbl_i      (tbl_q),
      .rd_addr_i  (bus.rd_addr[p*5 +: 5]),
      .rd_stage_i (bus.rd_stage[p*SW +: SW]),
      .rd_need_i  (bus.rd_need[p*SW +: SW]),
      .sel_o      (sel_w[p*SW +: SW]),
      .rdy_o      (rdy_w[p]),
      .hazard_o   (haz_w[p])
    );
  end

  assign md_haz_c    = bus.d_md_use & ((cnt_q != '0) | bus.md_start);
  assign stall_c     = !reset && bus.d_valid && ((|haz_w) || md_haz_c);
  assign bus.stall   = stall_c;
  assign bus.fwd_sel = sel_w;
  assign bus.fwd_rdy = rdy_w;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench: the driver queues hand-computed expectations per cycle, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_fwd_scoreboard;
  import fwd_scoreboard_pkg::*;

  localparam int unsigned NUM_RD = 4;
  localparam int unsigned SW     = 2;

  typedef struct {
    int cyc;
    int id;
    int port;   // -1: no port check, -2: full reset-value check
    int sel;
    int rdy;
    int stl;    // -1: don't care
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  exp_t mon_e;

  fwd_scoreboard_if #(.NUM_RD(NUM_RD), .SW(SW)) bus ();

  fwd_scoreboard #(
    .NUM_RD (NUM_RD),
    .DEPTH  (3),
    .MD_LAT (5),
    .SW     (SW)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int id, input string what, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL chk%0d %s: got %0d, want %0d (cycle %0d)", id, what, act, req, cyc);
    end
  endtask

  // Monitor: compare every expectation due this cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc != cyc) begin
        chk(mon_e.id, "late", cyc, mon_e.cyc);
      end else if (mon_e.port == -2) begin
        chk(mon_e.id, "rst_sel", int'(bus.fwd_sel), 0);
        chk(mon_e.id, "rst_rdy", int'(bus.fwd_rdy), 15);
        chk(mon_e.id, "rst_stall", int'(bus.stall), 0);
      end else begin
        if (mon_e.port >= 0) begin
          chk(mon_e.id, "sel", int'(bus.fwd_sel[mon_e.port*SW +: SW]), mon_e.sel);
          chk(mon_e.id, "rdy", int'(bus.fwd_rdy[mon_e.port]), mon_e.rdy);
        end
        if (mon_e.stl >= 0) chk(mon_e.id, "stall", int'(bus.stall), mon_e.stl);
      end
    end
  end

  task automatic exp_push(input int id, input int port, input int sel, input int rdy, input int stl);
    exp_t e;
    e.cyc = cyc; e.id = id; e.port = port; e.sel = sel; e.rdy = rdy; e.stl = stl;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.d_valid   = 1'b0;
    bus.d_wr_en   = 1'b0;
    bus.d_wr_addr = '0;
    bus.d_avail   = '0;
    bus.d_md_use  = 1'b0;
    bus.md_start  = 1'b0;
    bus.flush_e   = 1'b0;
    bus.rd_addr   = '0;
    bus.rd_stage  = '0;
    bus.rd_need   = '0;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic dwrite(input int addr, input int avail);
    idle();
    bus.d_valid   = 1'b1;
    bus.d_wr_en   = 1'b1;
    bus.d_wr_addr = 5'(addr);
    bus.d_avail   = SW'(avail);
  endtask

  task automatic set_port(input int p, input int addr, input int stg, input int need);
    bus.rd_addr[p*5 +: 5]   = 5'(addr);
    bus.rd_stage[p*SW +: SW] = SW'(stg);
    bus.rd_need[p*SW +: SW]  = SW'(need);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset with hazard-provoking inputs: outputs must still read as idle
    reset = 1'b1;
    dwrite(5, AVAIL_ALU);
    bus.d_md_use = 1'b1;
    bus.md_start = 1'b1;
    set_port(0, 5, 0, 0);
    tick();
    exp_push(1, -2, 0, 0, 0);
    tick();
    reset = 1'b0;

    // ALU result forwarded from M to an E-stage reader
    dwrite(5, AVAIL_ALU);
    exp_push(10, -1, 0, 0, 0);
    tick();
    idle(); bus.d_valid = 1'b1; set_port(0, 5, 0, 1);
    exp_push(11, 0, 1, 0, 0);
    tick();
    idle(); set_port(0, 5, 1, 0); set_port(1, 5, 2, 0);
    exp_push(12, 0, 2, 1, 0);
    exp_push(13, 1, 0, 1, -1);
    tick();
    drain();

    // Load-use: two stall cycles, then forward from W
    dwrite(7, AVAIL_LOAD);
    exp_push(20, -1, 0, 0, 0);
    tick();
    dwrite(9, AVAIL_ALU); set_port(0, 7, 0, 0);
    exp_push(21, 0, 1, 0, 1);
    tick();
    exp_push(22, 0, 2, 0, 1);
    tick();
    exp_push(23, 0, 3, 1, 0);
    tick();
    drain();

    // Same hazard with no valid D instruction: no stall
    dwrite(7, AVAIL_LOAD);
    tick();
    idle(); set_port(0, 7, 0, 0);
    exp_push(24, 0, 1, 0, 0);
    tick();
    drain();

    // jal in E feeding jr in D
    dwrite(31, AVAIL_JAL);
    tick();
    idle(); bus.d_valid = 1'b1; set_port(0, 31, 0, 0);
    exp_push(30, 0, 1, 1, 0);
    tick();
    drain();

    // Two producers of $8: youngest wins
    dwrite(8, AVAIL_ALU); tick();
    dwrite(3, AVAIL_ALU); tick();
    dwrite(8, AVAIL_ALU); tick();
    idle(); bus.d_valid = 1'b1; set_port(2, 8, 0, 1); set_port(3, 3, 0, 0);
    exp_push(40, 2, 1, 0, 0);
    exp_push(41, 3, 2, 1, -1);
    tick();
    drain();

    // $0 never tracked; flushed producer never tracked
    dwrite(0, AVAIL_ALU);
    tick();
    dwrite(10, AVAIL_LOAD); bus.flush_e = 1'b1; set_port(0, 0, 0, 0);
    exp_push(50, 0, 0, 1, 0);
    tick();
    idle(); bus.d_valid = 1'b1; set_port(1, 10, 0, 0);
    exp_push(51, 1, 0, 1, 0);
    tick();
    drain();

    // mult/div busy: start then mfhi stalls four cycles
    idle(); bus.md_start = 1'b1;
    exp_push(60, -1, 0, 0, 0);
    tick();
    idle(); bus.d_valid = 1'b1; bus.d_md_use = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_push(61 + i, -1, 0, 0, 1);
      tick();
    end
    exp_push(65, -1, 0, 0, 0);
    tick();
    drain();

    // Second start while busy reloads the counter
    idle(); bus.md_start = 1'b1;
    tick();
    bus.md_start = 1'b0; bus.d_valid = 1'b1; bus.d_md_use = 1'b1;
    exp_push(70, -1, 0, 0, 1);
    tick();
    bus.md_start = 1'b1;
    exp_push(71, -1, 0, 0, 1);
    tick();
    bus.md_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_push(72 + i, -1, 0, 0, 1);
      tick();
    end
    exp_push(76, -1, 0, 0, 0);
    tick();
    drain();

    // Reset mid load-stall and mid mult/div discards everything
    dwrite(7, AVAIL_LOAD); bus.md_start = 1'b1;
    tick();
    idle(); bus.d_valid = 1'b1; set_port(0, 7, 0, 0);
    exp_push(80, 0, 1, 0, 1);
    tick();
    reset = 1'b1;
    #1;
    exp_push(81, -2, 0, 0, 0);
    tick();
    reset = 1'b0;
    bus.d_md_use = 1'b1;
    exp_push(82, 0, 0, 1, 0);
    tick();
    drain();

    tick();
    chk(99, "pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
